frame_stream_gen: RTL and testbench

Parametrised, synthesizable video frame source for the Sobel pipeline. It replaces the fixed constant-pixel bench stimulus with a configurable streaming source. The block emits IMG_H x IMG_W pixels per frame over a valid/ready stream with a frame-end Last flag, in one of four test patterns. It obeys downstream backpressure exactly. It sits in front of the filter top, or in the bench in place of the DMA MM2S channel.

---
 rtl/frame_gen_pkg.sv | 17 +
 rtl/pixel_xy_counter.sv | 55 +++++
 rtl/frame_stream_gen.sv | 204 ++++++++++++++++++++
 tb/tb_frame_stream_gen.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_gen_pkg.sv
// Shared encodings for the frame stream generator: pattern modes and FSM states.
package frame_gen_pkg;

    localparam int unsigned FRAME_W = 8;
    localparam int unsigned MODE_W  = 2;

    localparam logic [MODE_W-1:0] MODE_CONST = 2'd0;
    localparam logic [MODE_W-1:0] MODE_HRAMP = 2'd1;
    localparam logic [MODE_W-1:0] MODE_VRAMP = 2'd2;
    localparam logic [MODE_W-1:0] MODE_CHECK = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pixel_xy_counter.sv
// Raster position counter: x within a line, y within a frame, 8-bit frame count.
// Holds the coordinates of the beat currently presented downstream.
module pixel_xy_counter
    import frame_gen_pkg::*;
#(
    parameter int unsigned IMG_W = 1280,
    parameter int unsigned IMG_H = 720,
    parameter int unsigned X_W   = $clog2(IMG_W),
    parameter int unsigned Y_W   = $clog2(IMG_H)
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               i_advance,
    input  logic               i_clear,
    output logic [X_W-1:0]     o_x,
    output logic [Y_W-1:0]     o_y,
    output logic [FRAME_W-1:0] o_frame,
    output logic               o_end_of_line,
    output logic               o_end_of_frame
);

    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic [FRAME_W-1:0] r_frame;

    logic               w_eol;
    logic               w_eof;

    assign w_eol = (r_x == X_W'(IMG_W - 1));
    assign w_eof = w_eol && (r_y == Y_W'(IMG_H - 1));

    // Clear wins over advance; x wraps into y, y wraps into the frame count.
    always_ff @(posedge Clk) begin
        if (Rst || i_clear) begin
            r_x     <= '0;
            r_y     <= '0;
            r_frame <= '0;
        end else if (i_advance) begin
            r_x <= w_eol ? '0 : X_W'(r_x + X_W'(1));
            if (w_eol) begin
                r_y <= w_eof ? '0 : Y_W'(r_y + Y_W'(1));
            end
            if (w_eof) begin
                r_frame <= FRAME_W'(r_frame + FRAME_W'(1));
            end
        end
    end

    assign o_x            = r_x;
    assign o_y            = r_y;
    assign o_frame        = r_frame;
    assign o_end_of_line  = w_eol;
    assign o_end_of_frame = w_eof;

endmodule

// File: rtl/frame_stream_gen.sv
// Streaming test-pattern frame source with valid/ready backpressure.
// Optional feature: define FRAME_GEN_SOF_EN to add the Sof_out start-of-frame flag.
module frame_stream_gen
    import frame_gen_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 1280,
    parameter int unsigned IMG_H  = 720
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic               Stop,
    input  logic [MODE_W-1:0]  Mode,
    input  logic [DATA_W-1:0]  Const_val,
    input  logic [FRAME_W-1:0] Num_frames,
    input  logic               Ready_from_IP,
    output logic               Valid_out,
    output logic [DATA_W-1:0]  Data_out,
    output logic               Last_out,
    output logic               Busy,
`ifdef FRAME_GEN_SOF_EN
    output logic               Frame_done,
    output logic               Sof_out
`else
    output logic               Frame_done
`endif
);

    localparam int unsigned X_W = $clog2(IMG_W);
    localparam int unsigned Y_W = $clog2(IMG_H);

    state_t              r_state,  w_state_nxt;
    logic [MODE_W-1:0]   r_mode,   w_mode_nxt;
    logic [DATA_W-1:0]   r_cval,   w_cval_nxt;
    logic [FRAME_W-1:0]  r_num,    w_num_nxt;
    logic                r_stop,   w_stop_nxt;
    logic                r_valid,  w_valid_nxt;
    logic [DATA_W-1:0]   r_data,   w_data_nxt;
    logic                r_last,   w_last_nxt;
    logic                r_busy,   w_busy_nxt;
    logic                r_done,   w_done_nxt;
`ifdef FRAME_GEN_SOF_EN
    logic                r_sof,    w_sof_nxt;
`endif

    logic [X_W-1:0]      w_x;
    logic [Y_W-1:0]      w_y;
    logic [FRAME_W-1:0]  w_frame;
    logic                w_eol;
    logic                w_eof;
    logic [X_W-1:0]      w_px;
    logic [Y_W-1:0]      w_py;
    logic                w_xfer;
    logic                w_start;
    logic                w_count_hit;
    logic                w_run_end;

    // Pattern value for a given mode, constant and raster position.
    function automatic logic [DATA_W-1:0] f_pattern(
        input logic [MODE_W-1:0] mode,
        input logic [DATA_W-1:0] cval,
        input logic [X_W-1:0]    x,
        input logic [Y_W-1:0]    y
    );
        logic [31:0] w_chk;
        w_chk = (32'(x) >> 3) ^ (32'(y) >> 3);
        case (mode)
            MODE_CONST: f_pattern = cval;
            MODE_HRAMP: f_pattern = DATA_W'(x);
            MODE_VRAMP: f_pattern = DATA_W'(y);
            default:    f_pattern = w_chk[0] ? '1 : '0;
        endcase
    endfunction

    pixel_xy_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_xy (
        .Clk            (Clk),
        .Rst            (Rst),
        .i_advance      (w_xfer),
        .i_clear        (w_start || w_run_end),
        .o_x            (w_x),
        .o_y            (w_y),
        .o_frame        (w_frame),
        .o_end_of_line  (w_eol),
        .o_end_of_frame (w_eof)
    );

    // Position of the beat that follows the one currently presented.
    assign w_px = w_eol ? '0 : X_W'(w_x + X_W'(1));
    assign w_py = w_eol ? (w_eof ? '0 : Y_W'(w_y + Y_W'(1))) : w_y;

    assign w_xfer      = r_valid && Ready_from_IP;
    assign w_start     = (r_state == IDLE) && Start;
    assign w_count_hit = (r_num != '0) && (FRAME_W'(w_frame + FRAME_W'(1)) == r_num);
    // A Stop arriving with the frame-end transfer still ends this frame.
    assign w_run_end   = (r_state == RUN) && w_xfer && w_eof
                         && (w_count_hit || r_stop || Stop);

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_cval_nxt  = r_cval;
        w_num_nxt   = r_num;
        w_stop_nxt  = r_stop;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_last_nxt  = r_last;
        w_done_nxt  = 1'b0;
`ifdef FRAME_GEN_SOF_EN
        w_sof_nxt   = r_sof;
`endif
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_state_nxt = RUN;
                    w_mode_nxt  = Mode;
                    w_cval_nxt  = Const_val;
                    w_num_nxt   = Num_frames;
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = f_pattern(Mode, Const_val, '0, '0);
                    w_last_nxt  = 1'b0;
`ifdef FRAME_GEN_SOF_EN
                    w_sof_nxt   = 1'b1;
`endif
                end
            end
            RUN: begin
                if (Stop) begin
                    w_stop_nxt = 1'b1;
                end
                if (w_run_end) begin
                    w_state_nxt = IDLE;
                    w_stop_nxt  = 1'b0;
                    w_valid_nxt = 1'b0;
                    w_data_nxt  = '0;
                    w_last_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
`ifdef FRAME_GEN_SOF_EN
                    w_sof_nxt   = 1'b0;
`endif
                end else if (w_xfer) begin
                    w_data_nxt = f_pattern(r_mode, r_cval, w_px, w_py);
                    w_last_nxt = (w_px == X_W'(IMG_W - 1)) && (w_py == Y_W'(IMG_H - 1));
`ifdef FRAME_GEN_SOF_EN
                    w_sof_nxt  = (w_px == '0) && (w_py == '0);
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == RUN);
    end

    // State, latched configuration and output registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
            r_mode  <= '0;
            r_cval  <= '0;
            r_num   <= '0;
            r_stop  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef FRAME_GEN_SOF_EN
            r_sof   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_cval  <= w_cval_nxt;
            r_num   <= w_num_nxt;
            r_stop  <= w_stop_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
`ifdef FRAME_GEN_SOF_EN
            r_sof   <= w_sof_nxt;
`endif
        end
    end

    assign Valid_out  = r_valid;
    assign Data_out   = r_data;
    assign Last_out   = r_last;
    assign Busy       = r_busy;
    assign Frame_done = r_done;
`ifdef FRAME_GEN_SOF_EN
    assign Sof_out    = r_sof;
`endif

endmodule

// File: tb/tb_frame_stream_gen.sv
// Self-checking bench for frame_stream_gen on a 4x3 image with 8-bit pixels.
// Define FRAME_GEN_SOF_EN to also exercise the Sof_out flag.
module tb_frame_stream_gen;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int NP = W * H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] cval = 8'd0;
    logic [7:0] nframes = 8'd0;
    logic       ready = 1'b0;
    logic       valid, last, busy, fdone, sof_o;
    logic [7:0] data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    frame_stream_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .Clk           (clk),
        .Rst           (rst),
        .Start         (start),
        .Stop          (stop),
        .Mode          (mode),
        .Const_val     (cval),
        .Num_frames    (nframes),
        .Ready_from_IP (ready),
        .Valid_out     (valid),
        .Data_out      (data),
        .Last_out      (last),
        .Busy          (busy),
`ifdef FRAME_GEN_SOF_EN
        .Frame_done    (fdone),
        .Sof_out       (sof_o)
`else
        .Frame_done    (fdone)
`endif
    );

`ifndef FRAME_GEN_SOF_EN
    assign sof_o = 1'b0;
`endif

    // Observed transfers and run-end observations filled in by collect().
    int   bd[$];
    bit   bl[$];
    bit   bs[$];
    int   bc[$];
    int   done_cnt, done_cyc, stall_viol;
    bit   busy_at_done, valid_at_done, done_next, valid_next, timed_out;
    logic [7:0] data_next;

    // Expected beats from the reference model.
    int   ed[$];
    bit   el[$];
    bit   es[$];

    function automatic int ref_pix(input int m, input int cv, input int x, input int y);
        case (m)
            0:       return cv;
            1:       return x % 256;
            2:       return y % 256;
            default: return (((x / 8) + (y / 8)) % 2) != 0 ? 255 : 0;
        endcase
    endfunction

    // Raster-order list of every beat of nf frames.
    task automatic build_exp(input int m, input int cv, input int nf);
        ed.delete(); el.delete(); es.delete();
        for (int f = 0; f < nf; f++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    ed.push_back(ref_pix(m, cv, x, y));
                    el.push_back(x == W - 1 && y == H - 1);
                    es.push_back(x == 0 && y == 0);
                end
    endtask

    // Called at a negedge; pulses Start for one edge and returns at the next negedge.
    task automatic do_start(input logic [1:0] m, input logic [7:0] cv, input logic [7:0] nf);
        start = 1'b1; mode = m; cval = cv; nframes = nf;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives ready/stop/start at negedges, records transfers until one cycle after Frame_done.
    task automatic collect(input int budget, input bit rnd, input int stop_at,
                           input int start_at, input int stall_at, input bit restart);
        bit prev_stall, fin, rdy;
        logic [7:0] pd;
        bit pl, ps;
        int stalls;
        bd.delete(); bl.delete(); bs.delete(); bc.delete();
        done_cnt = 0; done_cyc = -1; stall_viol = 0; timed_out = 1'b1;
        prev_stall = 1'b0; fin = 1'b0; stalls = 0; pd = '0; pl = 1'b0; ps = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (prev_stall && (valid !== 1'b1 || data !== pd || last !== pl || sof_o !== ps))
                stall_viol++;
            if (fin) begin
                done_next = fdone; valid_next = valid; data_next = data;
                ready = 1'b0; start = 1'b0; stop = 1'b0; timed_out = 1'b0;
                break;
            end
            if (fdone === 1'b1) begin
                done_cnt++; done_cyc = c; busy_at_done = busy; valid_at_done = valid;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall_at >= 0 && bd.size() == stall_at && stalls < 2) begin
                rdy = 1'b0; stalls++;
            end
            ready = rdy;
            stop  = (valid === 1'b1) && rdy && (bd.size() == stop_at);
            start = (start_at >= 0) && (bd.size() == start_at) && (valid === 1'b1);
            if (restart && fdone === 1'b1) start = 1'b1;
            if (valid === 1'b1 && rdy) begin
                bd.push_back(int'(data)); bl.push_back(last); bs.push_back(sof_o); bc.push_back(c);
            end
            prev_stall = (valid === 1'b1) && !rdy;
            pd = data; pl = last; ps = sof_o;
            if (fdone === 1'b1) fin = 1'b1;
            @(negedge clk);
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({valid, data, last, busy, fdone, sof_o} !== 13'd0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", {valid, data, last, busy, fdone, sof_o});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hramp_single();
        build_exp(1, 0, 1);
        do_start(2'd1, 8'd0, 8'd1);
        collect(100, 1'b0, -1, -1, -1, 1'b0);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL hramp_timeout got=1 want=0"); end
        total++; if (bd.size() != NP) begin bad++; $display("FAIL hramp_count got=%0d want=%0d", bd.size(), NP); end
        for (int i = 0; i < bd.size() && i < NP; i++) begin
            total++;
            if (bd[i] != ed[i] || bl[i] != el[i] || bc[i] != i) begin
                bad++; $display("FAIL hramp_beat%0d got=%0d/%0d@%0d want=%0d/%0d@%0d", i, bd[i], bl[i], bc[i], ed[i], el[i], i);
            end
        end
        total++;
        if (done_cnt != 1 || bc.size() == 0 || done_cyc != bc[bc.size()-1] + 1) begin
            bad++; $display("FAIL hramp_done got=cnt%0d@%0d want=cnt1@%0d", done_cnt, done_cyc, NP);
        end
        total++;
        if (busy_at_done !== 1'b0 || valid_at_done !== 1'b0 || done_next !== 1'b0) begin
            bad++; $display("FAIL hramp_end got=b%0d v%0d dn%0d want=000", busy_at_done, valid_at_done, done_next);
        end
    endtask

    task automatic test_vramp_two_frames();
        build_exp(2, 0, 2);
        do_start(2'd2, 8'd0, 8'd2);
        collect(100, 1'b0, -1, -1, -1, 1'b0);
        total++; if (bd.size() != 2 * NP || timed_out) begin bad++; $display("FAIL vramp_count got=%0d want=%0d", bd.size(), 2 * NP); end
        for (int i = 0; i < bd.size() && i < 2 * NP; i++) begin
            total++;
            if (bd[i] != ed[i] || bl[i] != el[i] || bc[i] != i) begin
                bad++; $display("FAIL vramp_beat%0d got=%0d/%0d@%0d want=%0d/%0d@%0d", i, bd[i], bl[i], bc[i], ed[i], el[i], i);
            end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL vramp_done_pulses got=%0d want=1", done_cnt); end
    endtask

    task automatic test_const_backpressure();
        build_exp(0, 8'hA5, 1);
        do_start(2'd0, 8'hA5, 8'd1);
        collect(400, 1'b1, -1, -1, -1, 1'b0);
        total++; if (bd.size() != NP || timed_out) begin bad++; $display("FAIL const_count got=%0d want=%0d", bd.size(), NP); end
        for (int i = 0; i < bd.size() && i < NP; i++) begin
            total++;
            if (bd[i] != ed[i] || bl[i] != el[i]) begin
                bad++; $display("FAIL const_beat%0d got=%0d/%0d want=%0d/%0d", i, bd[i], bl[i], ed[i], el[i]);
            end
        end
        total++; if (stall_viol != 0) begin bad++; $display("FAIL const_stall_hold got=%0d want=0", stall_viol); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL const_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_stop_checker();
        build_exp(3, 0, 2);
        do_start(2'd3, 8'd0, 8'd0);
        mode = 2'd1; cval = 8'h11; nframes = 8'd1;
        collect(200, 1'b1, NP + 4, 3, -1, 1'b0);
        total++; if (bd.size() != 2 * NP || timed_out) begin bad++; $display("FAIL stop_count got=%0d want=%0d", bd.size(), 2 * NP); end
        for (int i = 0; i < bd.size() && i < 2 * NP; i++) begin
            total++;
            if (bd[i] != ed[i] || bl[i] != el[i]) begin
                bad++; $display("FAIL stop_beat%0d got=%0d/%0d want=%0d/%0d", i, bd[i], bl[i], ed[i], el[i]);
            end
        end
        total++;
        if (done_cnt != 1 || busy_at_done !== 1'b0 || done_cyc != bc[bc.size()-1] + 1) begin
            bad++; $display("FAIL stop_end got=cnt%0d busy%0d want=cnt1 busy0", done_cnt, busy_at_done);
        end
        total++; if (stall_viol != 0) begin bad++; $display("FAIL stop_stall_hold got=%0d want=0", stall_viol); end
    endtask

    task automatic test_stop_at_frame_end();
        build_exp(1, 0, 1);
        do_start(2'd1, 8'd0, 8'd0);
        collect(100, 1'b0, NP - 1, -1, -1, 1'b0);
        total++;
        if (bd.size() != NP || done_cnt != 1 || timed_out) begin
            bad++; $display("FAIL stop_same_cycle got=%0d beats want=%0d", bd.size(), NP);
        end
    endtask

    task automatic test_back_to_back();
        do_start(2'd2, 8'd0, 8'd1);
        mode = 2'd0; cval = 8'h3C; nframes = 8'd1;
        collect(100, 1'b0, -1, -1, -1, 1'b1);
        total++; if (bd.size() != NP) begin bad++; $display("FAIL b2b_first_count got=%0d want=%0d", bd.size(), NP); end
        total++;
        if (valid_next !== 1'b1 || data_next !== 8'h3C) begin
            bad++; $display("FAIL b2b_restart got=v%0d d%h want=v1 d3c", valid_next, data_next);
        end
        build_exp(0, 8'h3C, 1);
        collect(100, 1'b0, -1, -1, -1, 1'b0);
        total++; if (bd.size() != NP || timed_out) begin bad++; $display("FAIL b2b_second_count got=%0d want=%0d", bd.size(), NP); end
        for (int i = 0; i < bd.size() && i < NP; i++) begin
            total++;
            if (bd[i] != ed[i] || bl[i] != el[i]) begin
                bad++; $display("FAIL b2b_beat%0d got=%0d/%0d want=%0d/%0d", i, bd[i], bl[i], ed[i], el[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int spurious;
        do_start(2'd1, 8'd0, 8'd1);
        ready = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; ready = 1'b0;
        total++;
        if ({valid, data, last, busy, fdone, sof_o} !== 13'd0) begin
            bad++; $display("FAIL midreset_outputs got=%h want=0", {valid, data, last, busy, fdone, sof_o});
        end
        spurious = 0;
        repeat (4) begin
            @(negedge clk);
            if (fdone !== 1'b0 || valid !== 1'b0) spurious++;
        end
        total++; if (spurious != 0) begin bad++; $display("FAIL midreset_quiet got=%0d want=0", spurious); end
        build_exp(1, 0, 1);
        do_start(2'd1, 8'd0, 8'd1);
        collect(100, 1'b0, -1, -1, -1, 1'b0);
        total++; if (bd.size() != NP || timed_out) begin bad++; $display("FAIL midreset_count got=%0d want=%0d", bd.size(), NP); end
        for (int i = 0; i < bd.size() && i < NP; i++) begin
            total++;
            if (bd[i] != ed[i] || bl[i] != el[i]) begin
                bad++; $display("FAIL midreset_beat%0d got=%0d/%0d want=%0d/%0d", i, bd[i], bl[i], ed[i], el[i]);
            end
        end
    endtask

`ifdef FRAME_GEN_SOF_EN
    task automatic test_sof();
        build_exp(1, 0, 2);
        do_start(2'd1, 8'd0, 8'd2);
        collect(200, 1'b0, -1, -1, NP, 1'b0);
        total++; if (bd.size() != 2 * NP || timed_out) begin bad++; $display("FAIL sof_count got=%0d want=%0d", bd.size(), 2 * NP); end
        for (int i = 0; i < bd.size() && i < 2 * NP; i++) begin
            total++;
            if (bs[i] != es[i] || bd[i] != ed[i]) begin
                bad++; $display("FAIL sof_beat%0d got=%0d/%0d want=%0d/%0d", i, bs[i], bd[i], es[i], ed[i]);
            end
        end
        total++; if (stall_viol != 0) begin bad++; $display("FAIL sof_stall_hold got=%0d want=0", stall_viol); end
    endtask
`endif

    initial begin
        test_reset();
        test_hramp_single();
        test_vramp_two_frames();
        test_const_backpressure();
        test_stop_checker();
        test_stop_at_frame_end();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef FRAME_GEN_SOF_EN
        test_sof();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
